// File: rtl/cluster_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cluster_load_sequencer
// Brief    : Descriptor-driven weight/act loader and compute handshake for
//            PE_cluster. CLUSTER_LOAD_PERF_EN adds load/compute cycle counters.
// Revision : 1.0 - initial release
// ============================================================================
module cluster_load_sequencer #(
  parameter int dataSize      = 8,
  parameter int idSize        = 8,
  parameter int addrSize      = 16,
  parameter int tagDepth      = 16,
  parameter int countSize     = 8,
  parameter int timeoutCycles = 4096
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic                 start_i,
  input  logic [countSize-1:0] acount_i,
  input  logic [countSize-1:0] wcount_i,
  input  logic [countSize-1:0] n_wtags_i,
  input  logic [countSize-1:0] n_atags_i,
  input  logic [addrSize-1:0]  w_base_i,
  input  logic [addrSize-1:0]  a_base_i,
  output logic                 tag_rd_en_o,
  output logic [((tagDepth > 1) ? $clog2(tagDepth) : 1)-1:0] tag_rd_addr_o,
  input  logic [2*idSize-1:0]  tag_rd_data_i,
  output logic                 w_rd_en_o,
  output logic                 a_rd_en_o,
  output logic [addrSize-1:0]  w_rd_addr_o,
  output logic [addrSize-1:0]  a_rd_addr_o,
  input  logic [dataSize-1:0]  w_rd_data_i,
  input  logic [dataSize-1:0]  a_rd_data_i,
  output logic [dataSize-1:0]  w_data_o,
  output logic [dataSize-1:0]  a_data_o,
  output logic [idSize-1:0]    weight_tag_x_o,
  output logic [idSize-1:0]    weight_tag_y_o,
  output logic [idSize-1:0]    act_tag_x_o,
  output logic [idSize-1:0]    act_tag_y_o,
  output logic                 start_compute_o,
  input  logic                 cluster_done_i,
  output logic                 busy_o,
  output logic                 done_o,
`ifdef CLUSTER_LOAD_PERF_EN
  output logic [31:0]          load_cycles_o,
  output logic [31:0]          compute_cycles_o,
`endif
  output logic                 error_o
);

  localparam int c_TAG_AW = (tagDepth > 1) ? $clog2(tagDepth) : 1;
  localparam int c_WD_W   = $clog2(timeoutCycles) + 1;
  localparam logic [c_WD_W-1:0]   c_WD_LAST  = c_WD_W'(timeoutCycles - 1);
  localparam logic [c_TAG_AW-1:0] c_TAG_LAST = c_TAG_AW'(tagDepth - 1);

  localparam logic [3:0] c_IDLE      = 4'd0;
  localparam logic [3:0] c_W_TAG     = 4'd1;
  localparam logic [3:0] c_W_STREAM  = 4'd2;
  localparam logic [3:0] c_A_TAG     = 4'd3;
  localparam logic [3:0] c_A_STREAM  = 4'd4;
  localparam logic [3:0] c_DRAIN     = 4'd5;
  localparam logic [3:0] c_START     = 4'd6;
  localparam logic [3:0] c_WAIT_DONE = 4'd7;
  localparam logic [3:0] c_FIN       = 4'd8;

  logic [3:0]           r_state;
  logic [countSize-1:0] r_wcount;
  logic [countSize-1:0] r_acount;
  logic [countSize-1:0] r_n_wtags;
  logic [countSize-1:0] r_n_atags;
  logic [addrSize-1:0]  r_w_base;
  logic [addrSize-1:0]  r_a_base;
  logic                 r_a_has;
  logic [addrSize-1:0]  r_w_ptr;
  logic [addrSize-1:0]  r_a_ptr;
  logic [countSize-1:0] r_elem_cnt;
  logic [countSize-1:0] r_tag_cnt;
  logic [c_TAG_AW-1:0]  r_tag_idx;
  logic [2*idSize-1:0]  r_tag;
  logic [c_WD_W-1:0]    r_wd;
  logic                 r_w_vld_p;
  logic                 r_a_vld_p;
  logic [2*idSize-1:0]  r_p_tag;

  logic                 w_overflow;
  logic                 w_accept;
  logic                 w_w_has;
  logic                 w_a_has;
  logic [c_TAG_AW-1:0]  w_act_idx;
  logic [c_TAG_AW-1:0]  w_tag_idx_inc;
  logic [2*idSize-1:0]  w_cur_tag;
  logic                 w_w_last_elem;
  logic                 w_a_last_elem;
  logic                 w_w_last_tag;
  logic                 w_a_last_tag;

  assign w_overflow = (32'(n_wtags_i) + 32'(n_atags_i)) > 32'(tagDepth);
  assign w_accept   = (r_state == c_IDLE) && start_i && !w_overflow;
  assign w_w_has    = (n_wtags_i != '0) && (wcount_i != '0);
  assign w_a_has    = (n_atags_i != '0) && (acount_i != '0);
  // Act descriptors follow the weight block even when the weight phase is skipped
  assign w_act_idx  = (32'(n_wtags_i) >= 32'(tagDepth)) ? '0 : c_TAG_AW'(n_wtags_i);
  assign w_tag_idx_inc = (r_tag_idx == c_TAG_LAST) ? '0 : r_tag_idx + c_TAG_AW'(1);

  // Descriptor word is only on the bus during the first stream cycle of a tag
  assign w_cur_tag     = (r_elem_cnt == '0) ? tag_rd_data_i : r_tag;
  assign w_w_last_elem = (r_elem_cnt == r_wcount - countSize'(1));
  assign w_a_last_elem = (r_elem_cnt == r_acount - countSize'(1));
  assign w_w_last_tag  = (r_tag_cnt == r_n_wtags - countSize'(1));
  assign w_a_last_tag  = (r_tag_cnt == r_n_atags - countSize'(1));

  assign tag_rd_en_o     = (r_state == c_W_TAG) || (r_state == c_A_TAG);
  assign tag_rd_addr_o   = r_tag_idx;
  assign w_rd_en_o       = (r_state == c_W_STREAM);
  assign a_rd_en_o       = (r_state == c_A_STREAM);
  assign w_rd_addr_o     = r_w_base + r_w_ptr;
  assign a_rd_addr_o     = r_a_base + r_a_ptr;
  assign start_compute_o = (r_state == c_START);
  assign busy_o          = (r_state != c_IDLE);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state    <= c_IDLE;
      r_wcount   <= '0;
      r_acount   <= '0;
      r_n_wtags  <= '0;
      r_n_atags  <= '0;
      r_w_base   <= '0;
      r_a_base   <= '0;
      r_a_has    <= 1'b0;
      r_w_ptr    <= '0;
      r_a_ptr    <= '0;
      r_elem_cnt <= '0;
      r_tag_cnt  <= '0;
      r_tag_idx  <= '0;
      r_tag      <= '0;
      r_wd       <= '0;
      done_o     <= 1'b0;
      error_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (start_i && w_overflow) begin
            error_o <= 1'b1;
          end else if (w_accept) begin
            error_o    <= 1'b0;
            r_wcount   <= wcount_i;
            r_acount   <= acount_i;
            r_n_wtags  <= n_wtags_i;
            r_n_atags  <= n_atags_i;
            r_w_base   <= w_base_i;
            r_a_base   <= a_base_i;
            r_a_has    <= w_a_has;
            r_w_ptr    <= '0;
            r_a_ptr    <= '0;
            r_elem_cnt <= '0;
            r_tag_cnt  <= '0;
            r_tag_idx  <= w_w_has ? '0 : w_act_idx;
            if (w_w_has)      r_state <= c_W_TAG;
            else if (w_a_has) r_state <= c_A_TAG;
            else              r_state <= c_START;
          end
        end
        c_W_TAG: begin
          r_tag_idx <= w_tag_idx_inc;
          r_state   <= c_W_STREAM;
        end
        c_W_STREAM: begin
          if (r_elem_cnt == '0) r_tag <= tag_rd_data_i;
          r_w_ptr <= r_w_ptr + addrSize'(1);
          if (w_w_last_elem) begin
            r_elem_cnt <= '0;
            if (w_w_last_tag) begin
              r_tag_cnt <= '0;
              r_state   <= r_a_has ? c_A_TAG : c_DRAIN;
            end else begin
              r_tag_cnt <= r_tag_cnt + countSize'(1);
              r_state   <= c_W_TAG;
            end
          end else begin
            r_elem_cnt <= r_elem_cnt + countSize'(1);
          end
        end
        c_A_TAG: begin
          r_tag_idx <= w_tag_idx_inc;
          r_state   <= c_A_STREAM;
        end
        c_A_STREAM: begin
          if (r_elem_cnt == '0) r_tag <= tag_rd_data_i;
          r_a_ptr <= r_a_ptr + addrSize'(1);
          if (w_a_last_elem) begin
            r_elem_cnt <= '0;
            if (w_a_last_tag) begin
              r_tag_cnt <= '0;
              r_state   <= c_DRAIN;
            end else begin
              r_tag_cnt <= r_tag_cnt + countSize'(1);
              r_state   <= c_A_TAG;
            end
          end else begin
            r_elem_cnt <= r_elem_cnt + countSize'(1);
          end
        end
        c_DRAIN: r_state <= c_START;
        c_START: begin
          r_wd    <= '0;
          r_state <= c_WAIT_DONE;
        end
        c_WAIT_DONE: begin
          if (cluster_done_i) begin
            r_state <= c_FIN;
          end else if (r_wd == c_WD_LAST) begin
            error_o <= 1'b1;
            r_state <= c_IDLE;
          end else begin
            r_wd <= r_wd + c_WD_W'(1);
          end
        end
        c_FIN: begin
          done_o  <= 1'b1;
          r_state <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  // Read data arrives one cycle after the strobe; register it with its tag
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_w_vld_p      <= 1'b0;
      r_a_vld_p      <= 1'b0;
      r_p_tag        <= '0;
      w_data_o       <= '0;
      a_data_o       <= '0;
      weight_tag_x_o <= '1;
      weight_tag_y_o <= '1;
      act_tag_x_o    <= '1;
      act_tag_y_o    <= '1;
    end else begin
      r_w_vld_p <= w_rd_en_o;
      r_a_vld_p <= a_rd_en_o;
      if (w_rd_en_o || a_rd_en_o) r_p_tag <= w_cur_tag;
      if (r_w_vld_p) begin
        w_data_o       <= w_rd_data_i;
        weight_tag_x_o <= r_p_tag[idSize-1:0];
        weight_tag_y_o <= r_p_tag[2*idSize-1:idSize];
      end else begin
        weight_tag_x_o <= '1;
        weight_tag_y_o <= '1;
      end
      if (r_a_vld_p) begin
        a_data_o    <= a_rd_data_i;
        act_tag_x_o <= r_p_tag[idSize-1:0];
        act_tag_y_o <= r_p_tag[2*idSize-1:idSize];
      end else begin
        act_tag_x_o <= '1;
        act_tag_y_o <= '1;
      end
    end
  end

`ifdef CLUSTER_LOAD_PERF_EN
  logic w_loading;
  assign w_loading = (r_state == c_W_TAG) || (r_state == c_W_STREAM) ||
                     (r_state == c_A_TAG) || (r_state == c_A_STREAM) ||
                     (r_state == c_DRAIN);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      load_cycles_o    <= '0;
      compute_cycles_o <= '0;
    end else if (w_accept) begin
      load_cycles_o    <= '0;
      compute_cycles_o <= '0;
    end else begin
      if (w_loading)                load_cycles_o    <= load_cycles_o + 32'd1;
      if (r_state == c_WAIT_DONE)   compute_cycles_o <= compute_cycles_o + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_cluster_load_sequencer.sv
`default_nettype none
// Testbench for cluster_load_sequencer: table of load scenarios plus
// directed reset, overflow and replay sequences.
module tb_cluster_load_sequencer;

  localparam int TO = 64;

  logic        clk;
  logic        nrst;
  logic        start_i;
  logic [7:0]  acount_i, wcount_i, n_wtags_i, n_atags_i;
  logic [15:0] w_base_i, a_base_i;
  logic        tag_rd_en_o;
  logic [3:0]  tag_rd_addr_o;
  logic [15:0] tag_rd_data_i;
  logic        w_rd_en_o, a_rd_en_o;
  logic [15:0] w_rd_addr_o, a_rd_addr_o;
  logic [7:0]  w_rd_data_i, a_rd_data_i;
  logic [7:0]  w_data_o, a_data_o;
  logic [7:0]  weight_tag_x_o, weight_tag_y_o, act_tag_x_o, act_tag_y_o;
  logic        start_compute_o;
  logic        cluster_done_i;
  logic        busy_o, done_o, error_o;
`ifdef CLUSTER_LOAD_PERF_EN
  logic [31:0] load_cycles_o, compute_cycles_o;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cluster_load_sequencer #(.timeoutCycles(TO)) dut (
    .clk(clk), .nrst(nrst), .start_i(start_i),
    .acount_i(acount_i), .wcount_i(wcount_i),
    .n_wtags_i(n_wtags_i), .n_atags_i(n_atags_i),
    .w_base_i(w_base_i), .a_base_i(a_base_i),
    .tag_rd_en_o(tag_rd_en_o), .tag_rd_addr_o(tag_rd_addr_o),
    .tag_rd_data_i(tag_rd_data_i),
    .w_rd_en_o(w_rd_en_o), .a_rd_en_o(a_rd_en_o),
    .w_rd_addr_o(w_rd_addr_o), .a_rd_addr_o(a_rd_addr_o),
    .w_rd_data_i(w_rd_data_i), .a_rd_data_i(a_rd_data_i),
    .w_data_o(w_data_o), .a_data_o(a_data_o),
    .weight_tag_x_o(weight_tag_x_o), .weight_tag_y_o(weight_tag_y_o),
    .act_tag_x_o(act_tag_x_o), .act_tag_y_o(act_tag_y_o),
    .start_compute_o(start_compute_o), .cluster_done_i(cluster_done_i),
    .busy_o(busy_o), .done_o(done_o),
`ifdef CLUSTER_LOAD_PERF_EN
    .load_cycles_o(load_cycles_o), .compute_cycles_o(compute_cycles_o),
`endif
    .error_o(error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] tagm(input int i);
    return {8'(i + 32), 8'(i)};
  endfunction
  function automatic logic [7:0] wdat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction
  function automatic logic [7:0] adat(input logic [15:0] a);
    return a[7:0] + a[15:8] + 8'h33;
  endfunction

  // Memories with one-cycle latency; garbage when not strobed
  always @(posedge clk) begin
    tag_rd_data_i <= tag_rd_en_o ? tagm(int'(tag_rd_addr_o)) : 16'hA5C3;
    w_rd_data_i   <= w_rd_en_o ? wdat(w_rd_addr_o) : 8'hEE;
    a_rd_data_i   <= a_rd_en_o ? adat(a_rd_addr_o) : 8'hDD;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  wc, ac, nw, na;
    logic [15:0] wb, ab;
    int          dly;
    bit          noise;
    int          exp_w, exp_a, exp_sc;
    bit          exp_err;
  } vec_t;

  function automatic vec_t mk(input int wc, input int ac, input int nw, input int na,
                              input logic [15:0] wb, input logic [15:0] ab,
                              input int dly, input bit noise,
                              input int ew, input int ea, input int esc, input bit eerr);
    vec_t v;
    v.wc = 8'(wc); v.ac = 8'(ac); v.nw = 8'(nw); v.na = 8'(na);
    v.wb = wb; v.ab = ab; v.dly = dly; v.noise = noise;
    v.exp_w = ew; v.exp_a = ea; v.exp_sc = esc; v.exp_err = eerr;
    return v;
  endfunction

  task automatic load_cfg(input vec_t v);
    wcount_i = v.wc; acount_i = v.ac; n_wtags_i = v.nw; n_atags_i = v.na;
    w_base_i = v.wb; a_base_i = v.ab;
  endtask

  // Entered and left on a negedge
  task automatic run_scn(input vec_t v);
    int nw, na, n_ws, n_as, bad_addr, bad_data, n_sc, n_done;
    int sc_cyc, done_cyc, fall_cyc, idx;
    bit ended;
    nw = 0; na = 0; n_ws = 0; n_as = 0; bad_addr = 0; bad_data = 0;
    n_sc = 0; n_done = 0; sc_cyc = -1; done_cyc = -1; fall_cyc = -1; ended = 0;
    load_cfg(v);
    start_i = 1'b1;
    @(negedge clk);
    check("err_cleared_on_start", 32'(error_o), 32'd0);
    for (int cyc = 1; cyc < 400 && !ended; cyc++) begin
      if (w_rd_en_o) begin
        if (w_rd_addr_o !== v.wb + 16'(n_ws)) bad_addr++;
        n_ws++;
      end
      if (a_rd_en_o) begin
        if (a_rd_addr_o !== v.ab + 16'(n_as)) bad_addr++;
        n_as++;
      end
      if (weight_tag_x_o !== 8'hFF || weight_tag_y_o !== 8'hFF) begin
        if (v.wc == 0) bad_data++;
        else begin
          idx = nw / int'(v.wc);
          if ({weight_tag_y_o, weight_tag_x_o} !== tagm(idx) ||
              w_data_o !== wdat(v.wb + 16'(nw))) bad_data++;
        end
        nw++;
      end
      if (act_tag_x_o !== 8'hFF || act_tag_y_o !== 8'hFF) begin
        if (v.ac == 0) bad_data++;
        else begin
          idx = (int'(v.nw) + na / int'(v.ac)) % 16;
          if ({act_tag_y_o, act_tag_x_o} !== tagm(idx) ||
              a_data_o !== adat(v.ab + 16'(na))) bad_data++;
        end
        na++;
      end
      if (start_compute_o) begin n_sc++; sc_cyc = cyc; end
      if (done_o) begin n_done++; done_cyc = cyc; end
      if (!busy_o && fall_cyc < 0) fall_cyc = cyc;
      if (fall_cyc >= 0 && cyc >= fall_cyc + 3) ended = 1;
      start_i        = v.noise && w_rd_en_o;
      cluster_done_i = (v.dly >= 0 && n_sc == 1 && cyc == sc_cyc + v.dly) ||
                       (v.noise && tag_rd_en_o);
      @(negedge clk);
    end
    start_i = 1'b0;
    cluster_done_i = 1'b0;
    if (!ended) begin
      n_checks++; n_fail++;
      $display("FAIL scenario_timeout: busy_o never dropped within cycle budget");
    end
    check("w_writes", 32'(nw), 32'(v.exp_w));
    check("a_writes", 32'(na), 32'(v.exp_a));
    check("w_strobes", 32'(n_ws), 32'(v.exp_w));
    check("a_strobes", 32'(n_as), 32'(v.exp_a));
    check("addr_errors", 32'(bad_addr), 32'd0);
    check("data_tag_errors", 32'(bad_data), 32'd0);
    check("start_pulses", 32'(n_sc), 32'd1);
    check("start_cycle", 32'(sc_cyc), 32'(v.exp_sc));
    check("done_pulses", 32'(n_done), (v.dly >= 0) ? 32'd1 : 32'd0);
    if (v.dly >= 0) check("done_cycle", 32'(done_cyc), 32'(v.exp_sc + v.dly + 2));
    check("busy_fall_cycle", 32'(fall_cyc),
          (v.dly >= 0) ? 32'(v.exp_sc + v.dly + 2) : 32'(v.exp_sc + TO + 1));
    check("error_final", 32'(error_o), 32'(v.exp_err));
`ifdef CLUSTER_LOAD_PERF_EN
    check("load_cycles", load_cycles_o, 32'(v.exp_sc - 1));
    check("compute_cycles", compute_cycles_o, (v.dly >= 0) ? 32'(v.dly) : 32'(TO));
`endif
  endtask

  vec_t vecs [8];

  initial begin
    int  cnt;
    bit  found;
    vecs[0] = mk(3, 5, 3, 3, 16'h0100, 16'h2000, 20, 0, 9, 15, 32, 0);
    vecs[1] = mk(2, 1, 1, 2, 16'h0300, 16'h0400, -1, 0, 2, 2, 9, 1);
    vecs[2] = mk(5, 5, 0, 1, 16'h0000, 16'h0500, 20, 0, 0, 5, 8, 0);
    vecs[3] = mk(0, 0, 2, 2, 16'h0000, 16'h0000, 5, 0, 0, 0, 1, 0);
    vecs[4] = mk(0, 2, 2, 1, 16'h0000, 16'h0600, 3, 0, 0, 2, 5, 0);
    vecs[5] = mk(1, 1, 10, 6, 16'hFFFC, 16'h0700, 1, 0, 10, 6, 34, 0);
    vecs[6] = mk(3, 5, 3, 3, 16'h0100, 16'h2000, 20, 1, 9, 15, 32, 0);
    vecs[7] = mk(2, 0, 2, 3, 16'h0800, 16'h0000, 2, 0, 4, 0, 8, 0);

    nrst = 1'b0; start_i = 1'b0; cluster_done_i = 1'b0;
    load_cfg(vecs[0]);
    @(negedge clk);
    @(negedge clk);
    check("rst_w_tag_x", 32'(weight_tag_x_o), 32'hFF);
    check("rst_w_tag_y", 32'(weight_tag_y_o), 32'hFF);
    check("rst_a_tag_x", 32'(act_tag_x_o), 32'hFF);
    check("rst_a_tag_y", 32'(act_tag_y_o), 32'hFF);
    check("rst_w_data", 32'(w_data_o), 32'd0);
    check("rst_a_data", 32'(a_data_o), 32'd0);
    check("rst_strobes", 32'({tag_rd_en_o, w_rd_en_o, a_rd_en_o, start_compute_o}), 32'd0);
    check("rst_flags", 32'({busy_o, done_o, error_o}), 32'd0);
    nrst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) run_scn(vecs[i]);

    // Descriptor overflow: rejected, error set, FSM stays idle
    wcount_i = 8'd1; acount_i = 8'd1; n_wtags_i = 8'd10; n_atags_i = 8'd7;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check("ovf_error", 32'(error_o), 32'd1);
    check("ovf_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    check("ovf_stays_idle", 32'({busy_o, tag_rd_en_o}), 32'd0);

    // Reset in the middle of the act stream, then replay from descriptor 0
    load_cfg(vecs[0]);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    cnt = 0; found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (a_rd_en_o) cnt++;
      if (cnt == 3) found = 1;
      else @(negedge clk);
    end
    check("mid_astream_reached", 32'(found), 32'd1);
    check("pre_rst_act_tag", 32'(act_tag_x_o), 32'd3);
    nrst = 1'b0;
    #1;
    check("mid_rst_a_tag", 32'({act_tag_y_o, act_tag_x_o}), 32'hFFFF);
    check("mid_rst_w_tag", 32'({weight_tag_y_o, weight_tag_x_o}), 32'hFFFF);
    check("mid_rst_strobes", 32'({tag_rd_en_o, w_rd_en_o, a_rd_en_o}), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    run_scn(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
